// File: rtl/bnn_pkg.sv
// bnn_pkg: shared word/result widths, sequencer state encoding and width helpers for the BNN layer
package bnn_pkg;
  localparam int WORD_W = 32;
  localparam int ACC_W = 32;
  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_WAIT,
    S_EMIT,
    S_DONE
  } seq_state_t;
  function automatic int addr_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction
endpackage

// File: rtl/bnn_dot_sequencer.sv
// bnn_dot_sequencer: streams packed activation/weight words into an XNOR-popcount engine one neuron at a time and emits binarised results; define BNN_SEQ_THRESH_EN for a signed threshold port
module bnn_dot_sequencer
  import bnn_pkg::*;
#(
  parameter int N_BITS = 256,
  parameter int N_OUT_MAX = 64,
  parameter int N_WORDS = N_BITS / WORD_W,
  parameter int OUT_W = cnt_w(N_OUT_MAX),
  parameter int WADDR_W = addr_w(N_OUT_MAX * N_WORDS),
  parameter int AADDR_W = addr_w(N_WORDS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [OUT_W-1:0]        n_out,
  output logic                    busy,
  output logic                    done,
  output logic                    act_rd_en,
  output logic [AADDR_W-1:0]      act_addr,
  input  logic [WORD_W-1:0]       act_rdata,
  output logic                    w_rd_en,
  output logic [WADDR_W-1:0]      w_addr,
  input  logic [WORD_W-1:0]       w_rdata,
  output logic                    dot_start,
  output logic [WORD_W-1:0]       dot_a_word,
  output logic [WORD_W-1:0]       dot_w_word,
  output logic                    dot_word_valid,
  output logic                    dot_last_word,
  input  logic                    dot_done,
  input  logic signed [ACC_W-1:0] dot_acc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_idx,
  output logic signed [ACC_W-1:0] out_acc,
  output logic                    out_bit
`ifdef BNN_SEQ_THRESH_EN
  ,
  input  logic signed [ACC_W-1:0] thresh
`endif
);
  localparam logic [AADDR_W-1:0] A_LAST = AADDR_W'(N_WORDS - 1);
  localparam logic [OUT_W-1:0] N_SAT = OUT_W'(N_OUT_MAX);
  seq_state_t state;
  logic [OUT_W-1:0] n_lat;
  logic [OUT_W-1:0] neuron;
  logic signed [ACC_W-1:0] th;
  assign dot_a_word = act_rdata;
  assign dot_w_word = w_rdata;
`ifdef BNN_SEQ_THRESH_EN
  assign th = thresh;
`else
  assign th = '0;
`endif
  // Sequencer: word issue counter, engine strobes, single-entry result holding stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      n_lat <= '0;
      neuron <= '0;
      act_rd_en <= 1'b0;
      w_rd_en <= 1'b0;
      act_addr <= '0;
      w_addr <= '0;
      dot_start <= 1'b0;
      dot_word_valid <= 1'b0;
      dot_last_word <= 1'b0;
      out_valid <= 1'b0;
      out_idx <= '0;
      out_acc <= '0;
      out_bit <= 1'b0;
    end else begin
      done <= 1'b0;
      dot_start <= 1'b0;
      dot_word_valid <= act_rd_en;
      dot_last_word <= act_rd_en && act_addr == A_LAST;
      case (state)
        S_IDLE: if (start) begin
          busy <= 1'b1;
          n_lat <= n_out > N_SAT ? N_SAT : n_out;
          neuron <= '0;
          if (n_out == '0) state <= S_DONE;
          else begin
            state <= S_ISSUE;
            act_rd_en <= 1'b1;
            w_rd_en <= 1'b1;
            act_addr <= '0;
            w_addr <= '0;
            dot_start <= 1'b1;
          end
        end
        S_ISSUE: if (act_addr == A_LAST) begin
          act_rd_en <= 1'b0;
          w_rd_en <= 1'b0;
          state <= S_DRAIN;
        end else begin
          act_addr <= act_addr + 1'b1;
          w_addr <= w_addr + 1'b1;
        end
        S_DRAIN: state <= S_WAIT;
        S_WAIT: if (dot_done) begin
          out_acc <= dot_acc;
          out_bit <= dot_acc >= th;
          out_idx <= neuron;
          out_valid <= 1'b1;
          state <= S_EMIT;
        end
        S_EMIT: if (out_ready) begin
          out_valid <= 1'b0;
          neuron <= neuron + 1'b1;
          if (neuron + 1'b1 == n_lat) begin
            state <= S_DONE;
            done <= 1'b1;
          end else begin
            state <= S_ISSUE;
            act_rd_en <= 1'b1;
            w_rd_en <= 1'b1;
            act_addr <= '0;
            w_addr <= w_addr + 1'b1;
            dot_start <= 1'b1;
          end
        end
        S_DONE: if (done) begin
          busy <= 1'b0;
          state <= S_IDLE;
        end else done <= 1'b1;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bnn_dot_sequencer.sv
// tb_bnn_dot_sequencer: scoreboard bench with memory and XNOR-popcount engine models; honours BNN_SEQ_THRESH_EN
module tb_bnn_dot_sequencer;
  typedef struct {
    int idx;
    int acc;
    int b;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic out_ready = 1'b1;
  logic [6:0] n_out = '0;
  logic busy, done, act_rd_en, w_rd_en, dot_start, dot_word_valid, dot_last_word;
  logic [2:0] act_addr;
  logic [8:0] w_addr;
  logic [31:0] act_rdata = '0, w_rdata = '0, dot_a_word, dot_w_word;
  logic dot_done = 1'b0;
  logic signed [31:0] dot_acc = '0;
  logic out_valid, out_bit;
  logic [6:0] out_idx;
  logic signed [31:0] out_acc;
`ifdef BNN_SEQ_THRESH_EN
  logic signed [31:0] thresh = '0;
`endif
  logic [31:0] act_mem [8];
  logic [31:0] w_mem [512];
  exp_t q[$];
  exp_t mon_e;
  int errors = 0, checks = 0, cyc = 0;
  int nd = 0, rk = 0, rd_cnt = 0, ov_cnt = 0, last_rise = 0, gap_exp = 0;
  bit pb = 0, pv = 0, have_last = 0;
  int eacc = 0;

  bnn_dot_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_out(n_out), .busy(busy), .done(done),
    .act_rd_en(act_rd_en), .act_addr(act_addr), .act_rdata(act_rdata),
    .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rdata(w_rdata),
    .dot_start(dot_start), .dot_a_word(dot_a_word), .dot_w_word(dot_w_word),
    .dot_word_valid(dot_word_valid), .dot_last_word(dot_last_word),
    .dot_done(dot_done), .dot_acc(dot_acc),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_acc(out_acc), .out_bit(out_bit)
`ifdef BNN_SEQ_THRESH_EN
    , .thresh(thresh)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // synchronous-read buffers, one cycle latency
  always @(posedge clk) begin
    if (act_rd_en) act_rdata <= act_mem[act_addr];
    if (w_rd_en) w_rdata <= w_mem[w_addr];
  end

  // behavioural XNOR-popcount engine: result one cycle after the last word
  always @(posedge clk) begin
    dot_done <= 1'b0;
    if (dot_start) eacc = 0;
    if (dot_word_valid) begin
      eacc = eacc + 2 * $countones(~(dot_a_word ^ dot_w_word)) - 32;
      if (dot_last_word) begin
        dot_done <= 1'b1;
        dot_acc <= eacc;
      end
    end
  end

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, got, exp, cyc);
    end
  endtask

  // monitor: read addressing, no reads under backpressure, result scoreboard
  always @(negedge clk) if (rst_n) begin
    if (busy && !pb) begin
      nd = 0;
      have_last = 0;
    end
    pb = busy;
    if (dot_start) begin
      rk = 0;
      chk("dot_start_vs_valid", dot_word_valid, 0);
    end
    if (act_rd_en) begin
      rd_cnt++;
      chk("act_addr", act_addr, rk);
      chk("w_addr", w_addr, nd * 8 + rk);
      rk++;
    end
    if (out_valid) begin
      chk("read_while_valid", act_rd_en | w_rd_en, 0);
      if (!pv) begin
        ov_cnt++;
        if (gap_exp != 0 && have_last) chk("valid_gap", cyc - last_rise, gap_exp);
        last_rise = cyc;
        have_last = 1;
      end
      if (q.size() == 0) chk("unexpected_out", 1, 0);
      else begin
        mon_e = q[0];
        chk("out_idx", out_idx, mon_e.idx);
        chk("out_acc", out_acc, mon_e.acc);
        chk("out_bit", out_bit, mon_e.b);
        if (out_ready) begin
          void'(q.pop_front());
          nd++;
        end
      end
    end
    pv = out_valid;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] low_mask(input int m);
    logic [32:0] t;
    t = (33'd1 << m) - 33'd1;
    return t[31:0];
  endfunction

  // weights of neuron n differ from the activations in exactly mism bit positions
  task automatic set_neuron(input int n, input int mism);
    int left = mism;
    for (int k = 0; k < 8; k++) begin
      int c = left > 32 ? 32 : left;
      w_mem[n * 8 + k] = act_mem[k] ^ low_mask(c);
      left -= c;
    end
  endtask

  task automatic set_act(input logic [31:0] seed);
    for (int k = 0; k < 8; k++) act_mem[k] = seed ^ (32'h9E3779B9 * (k + 1));
  endtask

  task automatic push(input int idx, input int acc, input int b);
    exp_t e;
    e.idx = idx;
    e.acc = acc;
    e.b = b;
    q.push_back(e);
  endtask

  task automatic do_start(input int n, output int s);
    tick;
    start = 1'b1;
    n_out = 7'(n);
    tick;
    start = 1'b0;
    s = cyc;
  endtask

  task automatic wait_done(input int exp_cyc, input string name);
    for (int i = 0; i < 2000 && !done; i++) tick;
    chk({name, "_done_cycle"}, done ? cyc : -1, exp_cyc);
    tick;
    chk({name, "_done_pulse"}, done, 0);
    chk({name, "_busy_low"}, busy, 0);
    chk({name, "_queue_empty"}, q.size(), 0);
  endtask

  task automatic chk_reset(input string name);
    chk({name, "_ctrl"}, {busy, done, out_valid, act_rd_en, w_rd_en, dot_start,
                          dot_word_valid, dot_last_word, out_bit}, 0);
    chk({name, "_out_acc"}, out_acc, 0);
    chk({name, "_out_idx"}, out_idx, 0);
    chk({name, "_addrs"}, {act_addr, w_addr}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s, r0, o0;
    repeat (3) tick;
    chk_reset("init");
    rst_n = 1'b1;
    tick;
    // single neuron, all ones
    for (int k = 0; k < 8; k++) act_mem[k] = 32'hFFFF_FFFF;
    set_neuron(0, 0);
    push(0, 256, 1);
    r0 = rd_cnt; o0 = ov_cnt;
    do_start(1, s);
    wait_done(s + 11, "t1");
    chk("t1_reads", rd_cnt - r0, 8);
    chk("t1_outs", ov_cnt - o0, 1);
    // three neurons, middle one anti-correlated; stray start while busy
    set_act(32'h1234_5678);
    set_neuron(0, 0); set_neuron(1, 256); set_neuron(2, 0);
    push(0, 256, 1); push(1, -256, 0); push(2, 256, 1);
    gap_exp = 11;
    r0 = rd_cnt; o0 = ov_cnt;
    do_start(3, s);
    repeat (4) tick;
    start = 1'b1; n_out = 7'd5;
    tick;
    start = 1'b0;
    wait_done(s + 33, "t2");
    chk("t2_reads", rd_cnt - r0, 24);
    chk("t2_outs", ov_cnt - o0, 3);
    gap_exp = 0;
    // backpressure on neuron 0
    set_act(32'hCAFE_F00D);
    set_neuron(0, 0); set_neuron(1, 64);
    push(0, 256, 1); push(1, 128, 1);
    out_ready = 1'b0;
    r0 = rd_cnt;
    do_start(2, s);
    for (int i = 0; i < 100 && !out_valid; i++) tick;
    chk("t3_valid_seen", out_valid, 1);
    repeat (5) tick;
    out_ready = 1'b1;
    wait_done(s + 27, "t3");
    chk("t3_reads", rd_cnt - r0, 16);
    // empty layer
    r0 = rd_cnt; o0 = ov_cnt;
    do_start(0, s);
    wait_done(s + 1, "t4");
    chk("t4_reads", rd_cnt - r0, 0);
    chk("t4_outs", ov_cnt - o0, 0);
    // reset during neuron 2 issue, then a fresh layer
    set_act(32'h0BAD_BEEF);
    for (int n = 0; n < 4; n++) set_neuron(n, 0);
    for (int n = 0; n < 4; n++) push(n, 256, 1);
    do_start(4, s);
    for (int i = 0; i < 200 && !(nd == 2 && act_rd_en); i++) tick;
    chk("t5_reached_n2", nd, 2);
    rst_n = 1'b0;
    #1;
    chk_reset("t5_rst");
    q.delete();
    tick; tick;
    rst_n = 1'b1;
    set_neuron(1, 200);
    push(0, 256, 1); push(1, -144, 0);
    r0 = rd_cnt;
    do_start(2, s);
    wait_done(s + 22, "t5b");
    chk("t5b_reads", rd_cnt - r0, 16);
    // binarisation boundary
    set_act(32'h5A5A_3C3C);
`ifdef BNN_SEQ_THRESH_EN
    thresh = 10;
    set_neuron(0, 124); set_neuron(1, 123); set_neuron(2, 122);
    push(0, 8, 0); push(1, 10, 1); push(2, 12, 1);
    do_start(3, s);
    wait_done(s + 33, "t6");
`else
    set_neuron(0, 129); set_neuron(1, 128);
    push(0, -2, 0); push(1, 0, 1);
    do_start(2, s);
    wait_done(s + 22, "t6");
`endif
    // n_out beyond the maximum saturates to 64 neurons
    set_act(32'h7777_1111);
    for (int n = 0; n < 64; n++) set_neuron(n, 0);
    for (int n = 0; n < 64; n++) push(n, 256, 1);
    r0 = rd_cnt; o0 = ov_cnt;
    do_start(100, s);
    wait_done(s + 704, "t7");
    chk("t7_reads", rd_cnt - r0, 512);
    chk("t7_outs", ov_cnt - o0, 64);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bnn_dot_sequencer.md
# bnn_dot_sequencer

Controller that runs one fully-connected binary layer on a single XNOR-popcount dot engine. It streams packed activation and weight words from two synchronous-read memories into the engine one neuron at a time. It captures each signed accumulator result, binarises it and presents it on a valid/ready result stream. It sits between the layer's activation/weight buffers and the dot engine inside the BNN layer top.

## Interface
- N_BITS, 256, input vector length in bits
- WORD_W, 32, packing width; only 32 supported by the dot engine
- N_WORDS, N_BITS/WORD_W, words per dot product (≥1)
- N_OUT_MAX, 64, maximum neurons per layer
- OUT_W, $clog2(N_OUT_MAX)+1, width of neuron count/index
- WADDR_W, $clog2(N_OUT_MAX*N_WORDS), weight memory address width
- AADDR_W, $clog2(N_WORDS) (min 1), activation memory address width

- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin layer; sampled only in IDLE
- n_out  in  OUT_W  neuron count, sampled with start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after last result handshake
- act_rd_en / act_addr  out  1 / AADDR_W  activation read
- act_rdata  in  WORD_W  activation data, 1-cycle latency
- w_rd_en / w_addr  out  1 / WADDR_W  weight read
- w_rdata  in  WORD_W  weight data, 1-cycle latency
- dot_start  out  1  clear engine accumulator
- dot_a_word / dot_w_word  out  WORD_W  = act_rdata / w_rdata (combinational pass-through)
- dot_word_valid / dot_last_word  out  1  word strobe / final word
- dot_done  in  1  engine result strobe (1 cycle after last word)
- dot_acc  in  32 signed  engine result
- thresh  in  32 signed  layer threshold (only with BNN_SEQ_THRESH_EN)
- out_valid / out_ready  out / in  1  result handshake
- out_idx  out  OUT_W  neuron index
- out_acc  out  32 signed  raw dot result
- out_bit  out  1  binarised activation

## Operation
- States: IDLE → ISSUE → DRAIN → WAIT → EMIT → (ISSUE | DONE) → IDLE.
- IDLE: start=1 latches n_out. If n_out=0, go to DONE directly. Otherwise clear neuron counter, go to ISSUE.
- ISSUE: N_WORDS cycles. Word k: act_rd_en=w_rd_en=1, act_addr=k, w_addr=neuron*N_WORDS+k. dot_start=1 only on k=0.
- Read-enable is registered one cycle to form dot_word_valid. dot_last_word is high with the valid of word N_WORDS-1.
- DRAIN: one cycle; last word valid presented, no reads.
- WAIT: wait for dot_done. Then register dot_acc into out_acc, out_bit and out_idx=neuron, and set out_valid.
- EMIT: hold out_* stable while out_valid && !out_ready.
  - On handshake, clear out_valid and increment neuron.
  - If neuron was n_out-1, go to DONE; else go to ISSUE.
- DONE: done=1 for one cycle, busy drops, return to IDLE.
- start while busy is ignored. n_out > N_OUT_MAX saturates to N_OUT_MAX.
- dot_start never coincides with dot_word_valid.
- Reset, including mid-layer: state IDLE. busy, done, out_valid, all rd_en, dot_start, dot_word_valid and dot_last_word are 0. out_acc=0, out_idx=0, out_bit=0, addresses=0.

## Timing
- Start accepted at cycle t. First ISSUE at t+1.
- Per neuron with ISSUE starting at cycle c:
  - reads at c..c+N_WORDS-1
  - word valids at c+1..c+N_WORDS
  - dot_done at c+N_WORDS+1
  - out_valid at c+N_WORDS+2
- With out_ready=1: handshake at c+N_WORDS+2, next ISSUE at c+N_WORDS+3. Period is N_WORDS+3 cycles.
- Final handshake at cycle h: done=1 at h+1, busy=0 from h+2.
- Backpressure stalls the whole sequencer; no read is issued while out_valid is high.

## Configuration
- BNN_SEQ_THRESH_EN defined:
  - thresh port exists.
  - out_bit = (dot_acc >= thresh), signed compare.
- Undefined:
  - no thresh port.
  - out_bit = (dot_acc >= 0), i.e. sign with 0 mapped to +1.

## Structure
- Shared package bnn_pkg: WORD_W constant, dot result width (32), sequencer state enum, address-width helper functions.
- No sub-module; the dot engine is instantiated beside this block in the layer top.
- Reads are issued by the state/word counter. The result register is a single-entry holding stage inside this block.

## Test plan
- N_WORDS=8, n_out=1; act words all 0xFFFFFFFF, weights all 0xFFFFFFFF → out_acc=+256, out_bit=1, out_idx=0, done 12 cycles after start.
- n_out=3; neuron 1 weights = ~activations → out_acc sequence +256, −256, +256; out_bit 1,0,1; out_valid intervals 11 cycles apart.
- Hold out_ready=0 for 5 cycles on neuron 0 → out_* stable, no act_rd_en/w_rd_en pulses; resumes after handshake. w_addr for neuron 1 starts at 8.
- n_out=0 → done pulse 2 cycles after start, no reads, no out_valid. A start pulse while busy → ignored, no counter change.
- Deassert rst_n during ISSUE of neuron 2 → all outputs at reset values immediately. A subsequent start runs a full layer from neuron 0.
- With BNN_SEQ_THRESH_EN, thresh=+10: dot results +8, +10, +12 → out_bit 0, 1, 1. Without the macro, −2, 0 → out_bit 0, 1.
